switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Per-output wormhole switch allocator for the mesh Router.
- Sits between the input buffers (route-computed head flits) and the crossbar.
- Shares each of the NUM_OF_PORTS output ports among the input ports with round-robin fairness.
- Locks an output to one input from head flit to tail flit and honours the downstream on/off flow control.

Parameters:
- NUM_OF_PORTS, 5, number of router ports (LOCAL, NORTH, SOUTH, WEST, EAST).
- PORT_W, $clog2(NUM_OF_PORTS) = 3, width of a port index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- i_req  in  NUM_OF_PORTS  per input: flit present at buffer head, requesting transfer.
- i_dst  in  NUM_OF_PORTS x PORT_W  per input: output port computed by routing.
- i_head  in  NUM_OF_PORTS  per input: flit is a head flit.
- i_tail  in  NUM_OF_PORTS  per input: flit is a tail flit (head+tail means a single-flit packet).
- i_on_off  in  NUM_OF_PORTS  per output: downstream can accept a flit this cycle.
- o_grant  out  NUM_OF_PORTS  per input: flit transfers this cycle; pop the buffer.
- o_xbar_sel  out  NUM_OF_PORTS x PORT_W  per output: selected input index.
- o_xbar_vld  out  NUM_OF_PORTS  per output: crossbar output carries a valid flit this cycle.
- o_err  out  1  sticky protocol error.

Behaviour:
- State per output o: lock state (IDLE/LOCKED), owner (PORT_W), rr_ptr (PORT_W).
- Reset values:
  - all outputs IDLE, owner = 0, rr_ptr = NUM_OF_PORTS-1, so input 0 has first priority;
  - o_err = 0.
- Output timing:
  - o_grant, o_xbar_sel and o_xbar_vld are combinational from the registered state and the current inputs.
  - Zero-cycle allocation latency: a flit is granted in the same cycle its request is seen.
  - State updates on the rising clk edge.
  - While reset is asserted, o_grant = 0, o_xbar_vld = 0 and o_xbar_sel = 0.
- Candidate for output o: input i with i_req[i] = 1 and i_dst[i] == o.
- IDLE behaviour:
  - Eligible set = candidates with i_head[i] = 1.
  - If the set is non-empty and i_on_off[o] = 1: pick the first eligible input scanning rr_ptr+1, rr_ptr+2, … modulo NUM_OF_PORTS.
  - On a pick: assert o_grant[winner], o_xbar_vld[o] = 1, o_xbar_sel[o] = winner; next rr_ptr = winner.
  - If the winner's i_tail = 0: next state LOCKED, owner = winner.
  - If head+tail: stay IDLE.
  - If i_on_off[o] = 0: no grant; state and rr_ptr hold.
- LOCKED behaviour:
  - Only the owner is served; requests from other inputs targeting o are held off (no grant, no error).
  - Owner granted iff i_req[owner] = 1, i_dst[owner] == o and i_on_off[o] = 1.
  - Owner granted with i_tail = 1: next state IDLE. rr_ptr stays = owner, so the owner has lowest priority next.
  - Owner idle (bubble) or i_on_off[o] = 0: hold LOCKED, no grant.
- Each input has a single i_dst, so at most one output grants a given input; o_grant is one-hot per input by construction.
- o_err is set (sticky until reset) on any of:
  - an i_dst value >= NUM_OF_PORTS with i_req = 1 (request ignored);
  - a non-head flit requesting an IDLE output (ignored);
  - a head flit from the owner while LOCKED (ignored).
- Boundaries:
  - Simultaneous tail of the current owner and new heads on the same output: the tail is granted this cycle; arbitration among the heads happens the next cycle.
  - rr_ptr wraps NUM_OF_PORTS-1 -> 0.
  - Reset asserted mid-packet: all locks dropped immediately (asynchronous). Upstream flushing is outside this block.
  - All NUM_OF_PORTS outputs allocate independently in the same cycle.

Decomposition:
- router_pkg holds:
  - NUM_OF_PORTS and PORT_W;
  - the port index constants LOCAL_PORT, NORTH_PORT, SOUTH_PORT, WEST_PORT, EAST_PORT;
  - typedef port_idx_t (logic [PORT_W-1:0]);
  - typedef alloc_state_t enum {IDLE, LOCKED}.
- One sub-module, rr_arbiter: a NUM_OF_PORTS-wide request vector plus pointer in, one-hot grant plus encoded index out, combinational. It is instantiated once per output inside a generate loop together with the per-output lock FSM.

Test Plan:
- Reset, then input 0 sends a single head+tail flit with i_dst=EAST, i_on_off[EAST]=1.
  - Same cycle: o_grant=00001, o_xbar_sel[EAST]=0, o_xbar_vld[EAST]=1.
  - Next cycle: EAST IDLE, rr_ptr=0.
- Inputs 1 and 3 each send a 3-flit packet (head, body, tail) to LOCAL at the same time, from reset (rr_ptr=4).
  - Input 1 is granted for 3 cycles, then input 3 for 3 cycles.
  - Input 3 receives no grant while LOCAL is locked to input 1.
- Input 2 is LOCKED on NORTH; i_on_off[NORTH]=0 for 4 cycles mid-packet.
  - No grant for those 4 cycles, state stays LOCKED.
  - The body flit is granted the first cycle i_on_off returns to 1.
- All 5 inputs hold single-flit packets to SOUTH continuously for 10 cycles.
  - Grant order 0,1,2,3,4,0,1,2,3,4, exactly one per cycle.
- Input 4 sends a body flit to an IDLE WEST, and input 0 sends with i_dst=6.
  - No grants; o_err=1 and it stays 1 until reset.
- Reset asserted while input 1 holds EAST LOCKED.
  - o_grant=0 immediately.
  - After release, a head from input 3 to EAST is granted on its first cycle.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router constants and types: port count, port index names,
// allocator lock state and a modulo helper for round-robin scanning.
package router_pkg;

    localparam int NUM_OF_PORTS = 5;
    localparam int PORT_W       = $clog2(NUM_OF_PORTS);

    typedef logic [PORT_W-1:0] port_idx_t;

    localparam port_idx_t LOCAL_PORT = port_idx_t'(0);
    localparam port_idx_t NORTH_PORT = port_idx_t'(1);
    localparam port_idx_t SOUTH_PORT = port_idx_t'(2);
    localparam port_idx_t WEST_PORT  = port_idx_t'(3);
    localparam port_idx_t EAST_PORT  = port_idx_t'(4);

    typedef enum logic {IDLE, LOCKED} alloc_state_t;

    // (base + k) modulo the port count, used to walk ports after the pointer
    function automatic port_idx_t port_add(port_idx_t base, int k);
        return port_idx_t'((int'(base) + k) % NUM_OF_PORTS);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request found scanning
// ptr+1, ptr+2, ... (wrapping) wins; one-hot grant plus encoded index.
module rr_arbiter
    import router_pkg::*;
(
    input  logic [NUM_OF_PORTS-1:0] req,
    input  logic [PORT_W-1:0]       ptr,
    output logic [NUM_OF_PORTS-1:0] gnt,
    output logic [PORT_W-1:0]       idx
);

    // Walk from the lowest priority up so the highest-priority hit is written last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NUM_OF_PORTS; k >= 1; k--) begin
            if (req[port_add(ptr, k)]) begin
                gnt                   = '0;
                gnt[port_add(ptr, k)] = 1'b1;
                idx                   = port_add(ptr, k);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator: round-robin among head flits, then
// the output stays locked to the winner until its tail flit passes.
module switch_allocator
    import router_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_OF_PORTS-1:0]        i_req,
    input  logic [NUM_OF_PORTS*PORT_W-1:0] i_dst,
    input  logic [NUM_OF_PORTS-1:0]        i_head,
    input  logic [NUM_OF_PORTS-1:0]        i_tail,
    input  logic [NUM_OF_PORTS-1:0]        i_on_off,
    output logic [NUM_OF_PORTS-1:0]        o_grant,
    output logic [NUM_OF_PORTS*PORT_W-1:0] o_xbar_sel,
    output logic [NUM_OF_PORTS-1:0]        o_xbar_vld,
    output logic                           o_err
);

    localparam port_idx_t NUM_P = port_idx_t'(NUM_OF_PORTS);

    port_idx_t                dst     [NUM_OF_PORTS];
    logic [NUM_OF_PORTS-1:0]  dst_ok;
    logic                     bad_dst;
    logic [NUM_OF_PORTS-1:0]  out_gnt [NUM_OF_PORTS];
    port_idx_t                out_sel [NUM_OF_PORTS];
    logic [NUM_OF_PORTS-1:0]  out_vld;
    logic [NUM_OF_PORTS-1:0]  out_err;

    // Out-of-range destinations never become candidates for any output.
    always_comb begin
        bad_dst = 1'b0;
        for (int i = 0; i < NUM_OF_PORTS; i++) begin
            dst[i]    = i_dst[i*PORT_W +: PORT_W];
            dst_ok[i] = i_req[i] && (dst[i] < NUM_P);
            if (i_req[i] && !(dst[i] < NUM_P))
                bad_dst = 1'b1;
        end
    end

    for (genvar o = 0; o < NUM_OF_PORTS; o++) begin : g_out
        localparam port_idx_t OUT_IDX = port_idx_t'(o);

        alloc_state_t            state_q, state_d;
        port_idx_t               owner_q, owner_d;
        port_idx_t               rr_q, rr_d;
        logic [NUM_OF_PORTS-1:0] cand, elig, arb_gnt, gnt_vec;
        port_idx_t               arb_idx, sel;
        logic                    arb_any, owner_fire, vld, err;

        always_comb begin
            for (int i = 0; i < NUM_OF_PORTS; i++)
                cand[i] = dst_ok[i] && (dst[i] == OUT_IDX);
        end

        assign elig    = cand & i_head;
        assign arb_any = |arb_gnt;

        rr_arbiter u_arb (
            .req (elig),
            .ptr (rr_q),
            .gnt (arb_gnt),
            .idx (arb_idx)
        );

        // A head flit from the current owner is a protocol error and never transfers.
        assign owner_fire = (state_q == LOCKED) && cand[owner_q] && !i_head[owner_q]
                            && i_on_off[o];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= IDLE;
                owner_q <= '0;
                rr_q    <= port_idx_t'(NUM_OF_PORTS - 1);
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                rr_q    <= rr_d;
            end
        end

        always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            rr_d    = rr_q;
            case (state_q)
                IDLE: begin
                    if (arb_any && i_on_off[o]) begin
                        rr_d = arb_idx;
                        if (!i_tail[arb_idx]) begin
                            state_d = LOCKED;
                            owner_d = arb_idx;
                        end
                    end
                end
                LOCKED: begin
                    if (owner_fire && i_tail[owner_q])
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        always_comb begin
            gnt_vec = '0;
            vld     = 1'b0;
            sel     = '0;
            err     = 1'b0;
            case (state_q)
                IDLE: begin
                    err = |(cand & ~i_head);
                    if (arb_any && i_on_off[o]) begin
                        gnt_vec = arb_gnt;
                        vld     = 1'b1;
                        sel     = arb_idx;
                    end
                end
                LOCKED: begin
                    err = cand[owner_q] && i_head[owner_q];
                    if (owner_fire) begin
                        gnt_vec[owner_q] = 1'b1;
                        vld              = 1'b1;
                        sel              = owner_q;
                    end
                end
                default: ;
            endcase
        end

        assign out_gnt[o] = gnt_vec;
        assign out_sel[o] = sel;
        assign out_vld[o] = vld;
        assign out_err[o] = err;
    end

    // Outputs are forced quiet while reset is held, independent of the clock.
    always_comb begin
        o_grant    = '0;
        o_xbar_vld = '0;
        o_xbar_sel = '0;
        if (!reset) begin
            for (int o = 0; o < NUM_OF_PORTS; o++) begin
                o_grant                         |= out_gnt[o];
                o_xbar_vld[o]                    = out_vld[o];
                o_xbar_sel[o*PORT_W +: PORT_W]   = out_sel[o];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            o_err <= 1'b0;
        else if (bad_dst || (|out_err))
            o_err <= 1'b1;
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus random
// traffic compared against a per-output behavioural model.
module tb_switch_allocator;
    import router_pkg::*;

    localparam int N = NUM_OF_PORTS;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     i_req, i_head, i_tail, i_on_off;
    logic [N*PORT_W-1:0] i_dst;
    logic [N-1:0]     o_grant, o_xbar_vld;
    logic [N*PORT_W-1:0] o_xbar_sel;
    logic             o_err;

    switch_allocator dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_dst      (i_dst),
        .i_head     (i_head),
        .i_tail     (i_tail),
        .i_on_off   (i_on_off),
        .o_grant    (o_grant),
        .o_xbar_sel (o_xbar_sel),
        .o_xbar_vld (o_xbar_vld),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Model state: per output a lock flag, owner and last-winner pointer.
    int  m_lock [N], m_own [N], m_ptr [N];
    int  n_lock [N], n_own [N], n_ptr [N];
    bit  m_err, n_err;
    logic [N-1:0]        exp_g, exp_v;
    logic [N*PORT_W-1:0] exp_sel;

    // Packet generator state per input.
    int plen [N], pos [N], pdst [N];

    function automatic int dst_of(int i);
        return int'(i_dst[i*PORT_W +: PORT_W]);
    endfunction

    function automatic logic [N*PORT_W-1:0] sel_mask(logic [N-1:0] v);
        logic [N*PORT_W-1:0] m;
        m = '0;
        for (int o = 0; o < N; o++)
            if (v[o]) m[o*PORT_W +: PORT_W] = '1;
        return m;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_lock[o] = 0; m_own[o] = 0; m_ptr[o] = N - 1;
        end
        m_err = 0;
    endtask

    task automatic model_eval();
        exp_g = '0; exp_v = '0; exp_sel = '0;
        n_err = m_err;
        for (int o = 0; o < N; o++) begin
            n_lock[o] = m_lock[o]; n_own[o] = m_own[o]; n_ptr[o] = m_ptr[o];
        end
        for (int i = 0; i < N; i++)
            if (i_req[i] && dst_of(i) >= N) n_err = 1;
        for (int o = 0; o < N; o++) begin
            if (m_lock[o] != 0) begin
                int own = m_own[o];
                if (i_req[own] && dst_of(own) == o) begin
                    if (i_head[own]) n_err = 1;
                    else if (i_on_off[o]) begin
                        exp_g[own] = 1'b1;
                        exp_v[o]   = 1'b1;
                        exp_sel[o*PORT_W +: PORT_W] = PORT_W'(own);
                        if (i_tail[own]) n_lock[o] = 0;
                    end
                end
            end else begin
                int win = -1;
                for (int i = 0; i < N; i++)
                    if (i_req[i] && dst_of(i) == o && !i_head[i]) n_err = 1;
                for (int k = 1; k <= N; k++) begin
                    int j = (m_ptr[o] + k) % N;
                    if (win < 0 && i_req[j] && dst_of(j) == o && i_head[j]) win = j;
                end
                if (win >= 0 && i_on_off[o]) begin
                    exp_g[win] = 1'b1;
                    exp_v[o]   = 1'b1;
                    exp_sel[o*PORT_W +: PORT_W] = PORT_W'(win);
                    n_ptr[o] = win;
                    if (!i_tail[win]) begin
                        n_lock[o] = 1; n_own[o] = win;
                    end
                end
            end
        end
    endtask

    task automatic clear_inputs();
        i_req = '0; i_head = '0; i_tail = '0; i_dst = '0; i_on_off = '1;
    endtask

    task automatic set_flit(input int i, input int d, input bit h, input bit t);
        i_req[i] = 1'b1;
        i_dst[i*PORT_W +: PORT_W] = PORT_W'(d);
        i_head[i] = h;
        i_tail[i] = t;
    endtask

    task automatic drive_pkts();
        i_req = '0; i_head = '0; i_tail = '0; i_dst = '0;
        for (int i = 0; i < N; i++)
            if (plen[i] > 0) set_flit(i, pdst[i], pos[i] == 0, pos[i] == plen[i] - 1);
    endtask

    task automatic advance_pkts();
        for (int i = 0; i < N; i++)
            if (plen[i] > 0 && exp_g[i]) begin
                pos[i]++;
                if (pos[i] == plen[i]) begin plen[i] = 0; pos[i] = 0; end
            end
    endtask

    task automatic eval_check(input string tag);
        #1;
        model_eval();
        check_eq({tag, "_gnt"}, 32'(o_grant), 32'(exp_g));
        check_eq({tag, "_vld"}, 32'(o_xbar_vld), 32'(exp_v));
        check_eq({tag, "_sel"}, 32'(o_xbar_sel & sel_mask(exp_v)), 32'(exp_sel));
        check_eq({tag, "_err"}, 32'(o_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int o = 0; o < N; o++) begin
            m_lock[o] = n_lock[o]; m_own[o] = n_own[o]; m_ptr[o] = n_ptr[o];
        end
        m_err = n_err;
        #1;
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check_eq({tag, "_rst_gnt"}, 32'(o_grant), 32'd0);
        check_eq({tag, "_rst_vld"}, 32'(o_xbar_vld), 32'd0);
        check_eq({tag, "_rst_sel"}, 32'(o_xbar_sel), 32'd0);
        check_eq({tag, "_rst_err"}, 32'(o_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin plen[i] = 0; pos[i] = 0; pdst[i] = 0; end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        apply_reset("init");

        // Single head+tail flit 0 -> EAST, then pointer now favours input 1.
        set_flit(0, int'(EAST_PORT), 1'b1, 1'b1);
        eval_check("s1");
        check_eq("s1_gnt_const", 32'(o_grant), 32'b00001);
        check_eq("s1_sel_east", 32'(o_xbar_sel[int'(EAST_PORT)*PORT_W +: PORT_W]), 32'd0);
        tick();
        clear_inputs();
        set_flit(0, int'(EAST_PORT), 1'b1, 1'b1);
        set_flit(1, int'(EAST_PORT), 1'b1, 1'b1);
        eval_check("s1_next");
        check_eq("s1_ptr_moved", 32'(o_grant), 32'b00010);
        tick();

        // Two 3-flit packets to LOCAL: input 1 fully, then input 3.
        apply_reset("s2");
        plen[1] = 3; pdst[1] = int'(LOCAL_PORT);
        plen[3] = 3; pdst[3] = int'(LOCAL_PORT);
        for (int c = 0; c < 6; c++) begin
            drive_pkts();
            eval_check("s2");
            check_eq("s2_order", 32'(o_grant), (c < 3) ? 32'b00010 : 32'b01000);
            advance_pkts();
            tick();
        end

        // Backpressure on NORTH mid-packet for 4 cycles.
        apply_reset("s3");
        plen[2] = 4; pdst[2] = int'(NORTH_PORT);
        for (int c = 0; c < 8; c++) begin
            drive_pkts();
            i_on_off = '1;
            if (c >= 2 && c < 6) i_on_off[NORTH_PORT] = 1'b0;
            eval_check("s3");
            check_eq("s3_hold", 32'(o_grant), (c < 2 || c >= 6) ? 32'b00100 : 32'd0);
            advance_pkts();
            tick();
        end

        // All inputs send single-flit packets to SOUTH: strict rotation.
        apply_reset("s4");
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            for (int i = 0; i < N; i++) set_flit(i, int'(SOUTH_PORT), 1'b1, 1'b1);
            eval_check("s4");
            check_eq("s4_rr", 32'(o_grant), 32'(1 << (c % N)));
            tick();
        end

        // Protocol errors: body flit to idle WEST and out-of-range destination.
        apply_reset("s5");
        set_flit(4, int'(WEST_PORT), 1'b0, 1'b0);
        set_flit(0, 6, 1'b1, 1'b1);
        eval_check("s5");
        check_eq("s5_nogrant", 32'(o_grant), 32'd0);
        tick();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            eval_check("s5_sticky");
            check_eq("s5_err", 32'(o_err), 32'd1);
            tick();
        end

        // Reset mid-packet drops the EAST lock; a fresh head wins at once.
        apply_reset("s6a");
        plen[1] = 4; pdst[1] = int'(EAST_PORT);
        for (int c = 0; c < 2; c++) begin
            drive_pkts();
            eval_check("s6_pre");
            advance_pkts();
            tick();
        end
        drive_pkts();
        apply_reset("s6");
        plen[3] = 2; pdst[3] = int'(EAST_PORT);
        drive_pkts();
        eval_check("s6_post");
        check_eq("s6_head3", 32'(o_grant), 32'b01000);
        advance_pkts();
        tick();

        // Random traffic: well-formed packets most of the time, raw noise after.
        apply_reset("rnd_a");
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                if (plen[i] == 0 && $urandom_range(0, 3) == 0) begin
                    plen[i] = $urandom_range(1, 4);
                    pdst[i] = $urandom_range(0, N - 1);
                    pos[i]  = 0;
                end
            drive_pkts();
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 4) == 0) i_req[i] = 1'b0;
            for (int o = 0; o < N; o++) i_on_off[o] = ($urandom_range(0, 3) != 0);
            eval_check("rnd_pkt");
            advance_pkts();
            tick();
        end
        apply_reset("rnd_b");
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < N; i++) begin
                i_req[i]  = $urandom_range(0, 1);
                i_head[i] = $urandom_range(0, 1);
                i_tail[i] = $urandom_range(0, 1);
                i_dst[i*PORT_W +: PORT_W] = ($urandom_range(0, 15) == 0)
                    ? PORT_W'($urandom_range(5, 7)) : PORT_W'($urandom_range(0, N - 1));
                i_on_off[i] = ($urandom_range(0, 3) != 0);
            end
            eval_check("rnd_raw");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
